fleet_placement_ctrl: RTL and testbench

FLEET_PLACEMENT_CTRL -- requirements
Module: fleet_placement_ctrl

---
 rtl/fleet_placement_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_fleet_placement_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fleet_placement_ctrl.sv
// ============================================================================
// Module   : fleet_placement_ctrl
// Purpose  : Fleet placement controller for a two-player board game. Walks
//            each player through direction, orientation and x/y entry for
//            every ship of the fleet, hands each candidate placement to an
//            external validator and emits a store pulse for accepted pieces.
// Options  : PLACE_CANCEL_EN - adds a 'cancel' strobe that returns the FSM
//            to DIR from ORI, DEF_X, DEF_Y or CHECK.
// Ports    : clk, reset (async, active-low)
//            start, mode, enter, select, coord_in  - user controls
//            chk_done, chk_conflict                - validator handshake in
//            x, y, tipo, direcao, orientacao, jogador - current piece
//            chk_req                               - validator request
//            wr_en, coord_err, conflict, ready     - status pulses / levels
//            state                                 - FSM state code
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fleet_placement_ctrl #(
    parameter int                              COORD_W    = 4,
    parameter int                              BOARD_N    = 8,
    parameter int                              NUM_TYPES  = 5,
    parameter int                              QTY_W      = 3,
    parameter logic [NUM_TYPES*QTY_W-1:0]      FLEET_QTY  = {3'd1, 3'd1, 3'd2, 3'd2, 3'd5},
    parameter int                              NUM_ORIENT = 5
) (
    input  logic               clk,
    input  logic               reset,
`ifdef PLACE_CANCEL_EN
    input  logic               cancel,
`endif
    input  logic               start,
    input  logic               mode,
    input  logic               enter,
    input  logic               select,
    input  logic [COORD_W-1:0] coord_in,
    input  logic               chk_done,
    input  logic               chk_conflict,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [2:0]         tipo,
    output logic               direcao,
    output logic [2:0]         orientacao,
    output logic               jogador,
    output logic               chk_req,
    output logic               wr_en,
    output logic               coord_err,
    output logic               conflict,
    output logic               ready,
    output logic [2:0]         state
);

    localparam int                 TYPE_W    = 3;
    localparam logic [COORD_W:0]   BOARD_LIM = (COORD_W+1)'(BOARD_N);
    localparam logic [2:0]         ORI_MAX   = 3'(NUM_ORIENT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIR   = 3'd1,
        ORI   = 3'd2,
        DEF_X = 3'd3,
        DEF_Y = 3'd4,
        CHECK = 3'd5,
        STORE = 3'd6,
        DONE  = 3'd7
    } state_t;

    // Ship count configured for a given type.
    function automatic logic [QTY_W-1:0] qty_of(input logic [TYPE_W-1:0] sel);
        logic [QTY_W-1:0] r;
        r = '0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (int'(sel) == t) r = FLEET_QTY[t*QTY_W +: QTY_W];
        end
        return r;
    endfunction

    // True when some type at index >= from has a non-zero quantity.
    function automatic logic has_type(input int from);
        logic r;
        r = 1'b0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (t >= from && FLEET_QTY[t*QTY_W +: QTY_W] != '0) r = 1'b1;
        end
        return r;
    endfunction

    // Lowest type index >= from with a non-zero quantity (0 when none).
    function automatic logic [TYPE_W-1:0] next_type(input int from);
        logic [TYPE_W-1:0] r;
        r = '0;
        for (int t = NUM_TYPES - 1; t >= 0; t--) begin
            if (t >= from && FLEET_QTY[t*QTY_W +: QTY_W] != '0) r = TYPE_W'(t);
        end
        return r;
    endfunction

    state_t             cur_state, nxt_state;
    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic [TYPE_W-1:0]  tipo_nxt;
    logic [QTY_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic               dir_nxt;
    logic [2:0]         ori_nxt;
    logic               jog_nxt;
    logic               mode_lat, mode_nxt;
    logic               coord_err_nxt, conflict_nxt;
    logic               coord_ok;
    logic               last_player;
    logic               more_types;
    logic [TYPE_W-1:0]  first_type, adv_type;

    assign coord_ok    = {1'b0, coord_in} < BOARD_LIM;
    assign last_player = mode_lat;
    assign cnt_inc     = cnt + QTY_W'(1);
    // Zero-quantity types are skipped both at session/player start and when
    // advancing, so no placement is ever requested for them.
    assign first_type  = next_type(0);
    assign adv_type    = next_type(int'(tipo) + 1);
    assign more_types  = has_type(int'(tipo) + 1);

    // Level outputs decoded directly from the state so that they follow the
    // asynchronous reset without an extra register stage.
    assign state   = cur_state;
    assign chk_req = (cur_state == CHECK);
    assign wr_en   = (cur_state == STORE);
    assign ready   = (cur_state == DONE);

    always_comb begin
        nxt_state     = cur_state;
        x_nxt         = x;
        y_nxt         = y;
        tipo_nxt      = tipo;
        cnt_nxt       = cnt;
        dir_nxt       = direcao;
        ori_nxt       = orientacao;
        jog_nxt       = jogador;
        mode_nxt      = mode_lat;
        coord_err_nxt = 1'b0;
        conflict_nxt  = 1'b0;

        case (cur_state)
            IDLE, DONE: begin
                if (start) begin
                    nxt_state = DIR;
                    tipo_nxt  = first_type;
                    cnt_nxt   = '0;
                    jog_nxt   = 1'b0;
                    mode_nxt  = mode;
                end
            end
            DIR: begin
                if (enter)       nxt_state = ORI;
                else if (select) dir_nxt   = ~direcao;
            end
            ORI: begin
                if (enter)       nxt_state = DEF_X;
                else if (select) ori_nxt   = (orientacao == ORI_MAX) ? 3'd0 : orientacao + 3'd1;
            end
            DEF_X: begin
                if (enter) begin
                    if (coord_ok) begin
                        x_nxt     = coord_in;
                        nxt_state = DEF_Y;
                    end else begin
                        coord_err_nxt = 1'b1;
                    end
                end
            end
            DEF_Y: begin
                if (enter) begin
                    if (coord_ok) begin
                        y_nxt     = coord_in;
                        nxt_state = CHECK;
                    end else begin
                        coord_err_nxt = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (chk_done) begin
                    if (chk_conflict) begin
                        conflict_nxt = 1'b1;
                        nxt_state    = DEF_X;
                    end else begin
                        nxt_state = STORE;
                    end
                end
            end
            STORE: begin
                nxt_state = DIR;
                if (cnt_inc == qty_of(tipo)) begin
                    cnt_nxt = '0;
                    if (more_types) begin
                        tipo_nxt = adv_type;
                    end else if (jogador == last_player) begin
                        nxt_state = DONE;
                    end else begin
                        jog_nxt  = 1'b1;
                        tipo_nxt = first_type;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: nxt_state = IDLE;
        endcase

`ifdef PLACE_CANCEL_EN
        // Cancel wins over everything else: throw away any pending update
        // and return to direction entry with coordinates and progress intact.
        if (cancel && (cur_state == ORI || cur_state == DEF_X ||
                       cur_state == DEF_Y || cur_state == CHECK)) begin
            nxt_state     = DIR;
            x_nxt         = x;
            y_nxt         = y;
            tipo_nxt      = tipo;
            cnt_nxt       = cnt;
            dir_nxt       = direcao;
            ori_nxt       = orientacao;
            coord_err_nxt = 1'b0;
            conflict_nxt  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state  <= IDLE;
            x          <= '0;
            y          <= '0;
            tipo       <= '0;
            cnt        <= '0;
            direcao    <= 1'b0;
            orientacao <= 3'd0;
            jogador    <= 1'b0;
            mode_lat   <= 1'b0;
            coord_err  <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            x          <= x_nxt;
            y          <= y_nxt;
            tipo       <= tipo_nxt;
            cnt        <= cnt_nxt;
            direcao    <= dir_nxt;
            orientacao <= ori_nxt;
            jogador    <= jog_nxt;
            mode_lat   <= mode_nxt;
            coord_err  <= coord_err_nxt;
            conflict   <= conflict_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fleet_placement_ctrl.sv
// ============================================================================
// Module   : tb_fleet_placement_ctrl
// Purpose  : Self-checking bench for fleet_placement_ctrl. A queue of
//            expected (player, type) pieces is built from the fleet table and
//            consumed by every store pulse; user and validator stimulus is
//            randomized.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fleet_placement_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, mode, enter, select;
    logic [3:0] coord_in;
    logic       chk_done, chk_conflict;
    logic [3:0] x, y;
    logic [2:0] tipo;
    logic       direcao;
    logic [2:0] orientacao;
    logic       jogador, chk_req, wr_en, coord_err, conflict, ready;
    logic [2:0] state;
`ifdef PLACE_CANCEL_EN
    logic       cancel = 1'b0;
`endif

    fleet_placement_ctrl dut (
        .clk          (clk),
        .reset        (rst_n),
`ifdef PLACE_CANCEL_EN
        .cancel       (cancel),
`endif
        .start        (start),
        .mode         (mode),
        .enter        (enter),
        .select       (select),
        .coord_in     (coord_in),
        .chk_done     (chk_done),
        .chk_conflict (chk_conflict),
        .x            (x),
        .y            (y),
        .tipo         (tipo),
        .direcao      (direcao),
        .orientacao   (orientacao),
        .jogador      (jogador),
        .chk_req      (chk_req),
        .wr_en        (wr_en),
        .coord_err    (coord_err),
        .conflict     (conflict),
        .ready        (ready),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct { int jog; int tip; } piece_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     qty_tab[5] = '{5, 2, 2, 1, 1};
    piece_t exp_q[$];
    int     exp_x = 0, exp_y = 0, exp_dir = 0, exp_ori = 0;
    int     wr_cnt = 0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned all_outs();
        return {8'd0, x, y, tipo, direcao, orientacao, jogador, chk_req,
                wr_en, coord_err, conflict, ready, state};
    endfunction

    // Every store pulse must match the next expected piece and coordinates.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check_val("wr_unexpected", 1, 0);
            end else begin
                piece_t e;
                e = exp_q.pop_front();
                check_val("wr_tipo", tipo, e.tip);
                check_val("wr_jogador", jogador, e.jog);
                check_val("wr_x", x, exp_x);
                check_val("wr_y", y, exp_y);
            end
        end
    end

    task automatic build_queue(input int m);
        exp_q.delete();
        for (int p = 0; p <= m; p++)
            for (int t = 0; t < 5; t++)
                for (int k = 0; k < qty_tab[t]; k++)
                    exp_q.push_back('{p, t});
    endtask

    task automatic press(input bit e, input bit s, input int c);
        enter    = e;
        select   = s;
        coord_in = 4'(c);
        @(negedge clk);
        enter  = 1'b0;
        select = 1'b0;
    endtask

    task automatic do_coord(input int axis);
        int c;
        if ($urandom_range(0, 3) == 0) begin
            c = $urandom_range(8, 15);
            press(1'b1, 1'b0, c);
            check_val("coord_err_bad", coord_err, 1);
            check_val("state_bad_coord", state, 3 + axis);
            check_val("coord_hold", axis ? y : x, axis ? exp_y : exp_x);
        end
        c = $urandom_range(0, 7);
        press(1'b1, 1'b0, c);
        if (axis == 0) exp_x = c; else exp_y = c;
        check_val("coord_err_ok", coord_err, 0);
        check_val("state_after_coord", state, 4 + axis);
        check_val("coord_latch", axis ? y : x, c);
    endtask

    task automatic validate(output bit ok);
        int n;
        n = $urandom_range(0, 3);
        repeat (n) begin
            chk_conflict = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val("chk_req_hold", chk_req, 1);
        end
        if ($urandom_range(0, 3) == 0) begin
            chk_done = 1'b1; chk_conflict = 1'b1;
            @(negedge clk);
            chk_done = 1'b0; chk_conflict = 1'b0;
            check_val("conflict_pulse", conflict, 1);
            check_val("conflict_state", state, 3);
            check_val("conflict_no_wr", wr_en, 0);
            check_val("conflict_chk_req", chk_req, 0);
            check_val("conflict_dir", direcao, exp_dir);
            check_val("conflict_ori", orientacao, exp_ori);
            @(negedge clk);
            check_val("conflict_one_cycle", conflict, 0);
            ok = 1'b0;
        end else begin
            chk_done = 1'b1; chk_conflict = 1'b0;
            @(negedge clk);
            chk_done = 1'b0;
            check_val("store_state", state, 6);
            check_val("store_wr", wr_en, 1);
            @(negedge clk);
            check_val("store_one_cycle", wr_en, 0);
            ok = 1'b1;
        end
    endtask

    task automatic check_after_piece(input bit last);
        if (last) begin
            check_val("done_state", state, 7);
            check_val("done_ready", ready, 1);
        end else begin
            check_val("next_state", state, 1);
            check_val("next_ready", ready, 0);
        end
    endtask

    task automatic place_piece(input bit last);
        bit ok;
        int n;
        check_val("piece_state", state, 1);
        if (exp_q.size() > 0) begin
            check_val("piece_tipo", tipo, exp_q[0].tip);
            check_val("piece_jogador", jogador, exp_q[0].jog);
        end
        n = $urandom_range(0, 3);
        repeat (n) begin
            press(1'b0, 1'b1, 0);
            exp_dir = exp_dir ^ 1;
        end
        check_val("direcao", direcao, exp_dir);
        press(1'b1, 1'b0, 0);
        check_val("ori_state", state, 2);
        n = $urandom_range(0, 6);
        repeat (n) begin
            press(1'b0, 1'b1, 0);
            exp_ori = (exp_ori + 1) % 5;
            check_val("orientacao", orientacao, exp_ori);
        end
        press(1'b1, 1'($urandom_range(0, 1)), 0);
        check_val("defx_state", state, 3);
        check_val("ori_kept", orientacao, exp_ori);
        ok = 1'b0;
        while (!ok) begin
            do_coord(0);
            do_coord(1);
            check_val("chk_req_rise", chk_req, 1);
            validate(ok);
        end
        check_after_piece(last);
    endtask

    // Fixed first piece: orientation wrap, enter+select, bad coordinate,
    // validator rejection and clean re-entry at (3,4).
    task automatic directed_piece(input bit last);
        press(1'b1, 1'b0, 0);
        while (exp_ori != 4) begin
            press(1'b0, 1'b1, 0);
            exp_ori = (exp_ori + 1) % 5;
        end
        check_val("ori_at_4", orientacao, 4);
        press(1'b0, 1'b1, 0);
        exp_ori = 0;
        check_val("ori_wrap", orientacao, 0);
        press(1'b1, 1'b1, 0);
        check_val("enter_sel_state", state, 3);
        check_val("enter_sel_ori", orientacao, 0);
        press(1'b1, 1'b0, 9);
        check_val("x9_coord_err", coord_err, 1);
        check_val("x9_state", state, 3);
        press(1'b1, 1'b0, 2);
        exp_x = 2;
        check_val("x2_latch", x, 2);
        check_val("x2_state", state, 4);
        press(1'b1, 1'b0, 5);
        exp_y = 5;
        check_val("y5_state", state, 5);
        chk_done = 1'b1; chk_conflict = 1'b1;
        @(negedge clk);
        chk_done = 1'b0; chk_conflict = 1'b0;
        check_val("dir_conflict", conflict, 1);
        check_val("dir_conflict_state", state, 3);
        check_val("dir_conflict_wr", wr_en, 0);
        press(1'b1, 1'b0, 3);
        exp_x = 3;
        press(1'b1, 1'b0, 4);
        exp_y = 4;
        check_val("reentry_state", state, 5);
        chk_done = 1'b1;
        @(negedge clk);
        chk_done = 1'b0;
        check_val("reentry_wr", wr_en, 1);
        check_val("reentry_x", x, 3);
        check_val("reentry_y", y, 4);
        @(negedge clk);
        check_after_piece(last);
    endtask

    task automatic run_session(input bit m, input bit directed);
        int total;
        total = 11 * (int'(m) + 1);
        build_queue(int'(m));
        wr_cnt = 0;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        check_val("start_state", state, 1);
        check_val("start_tipo", tipo, 0);
        check_val("start_jogador", jogador, 0);
        check_val("start_ready", ready, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("start_ignored", state, 1);
        for (int i = 0; i < total; i++) begin
            if (directed && i == 0) directed_piece(1'b0);
            else                    place_piece(i == total - 1);
        end
        check_val("wr_total", wr_cnt, total);
        check_val("queue_left", exp_q.size(), 0);
        check_val("final_state", state, 7);
    endtask

    task automatic reset_in_check();
        build_queue(1);
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        press(1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 1);
        press(1'b1, 1'b0, 6);
        check_val("pre_reset_chk_req", chk_req, 1);
        check_val("pre_reset_state", state, 5);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset_outs", all_outs(), 0);
        exp_q.delete();
        exp_x = 0; exp_y = 0; exp_dir = 0; exp_ori = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            chk_done = 1'b1;
            enter    = 1'b1;
            @(negedge clk);
        end
        chk_done = 1'b0;
        enter    = 1'b0;
        check_val("post_reset_state", state, 0);
        check_val("post_reset_wr", wr_en, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; mode = 1'b0; enter = 1'b0; select = 1'b0;
        coord_in = 4'd0; chk_done = 1'b0; chk_conflict = 1'b0;
        #3;
        check_val("reset_outs", all_outs(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_state", state, 0);

        run_session(1'b0, 1'b1);
        run_session(1'b1, 1'b0);
        reset_in_check();
        run_session(1'b0, 1'b0);
        run_session(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
